// File: rtl/ttt_game_ctrl.sv
// -----------------------------------------------------------------------------
// ttt_game_ctrl
//   Turn sequencer for a two-player tic-tac-toe board. The controller owns
//   the 3x3 board, accepts or rejects moves, alternates turns, and takes its
//   win/tie decision from external combinational win logic. The same logic
//   sees the board one cycle after each accepted move. Each finished game is
//   recorded in saturating tallies. The opening player alternates between
//   consecutive games.
//
//   Optional feature: define MOVE_TIMEOUT_EN to forfeit a turn after
//   TIMEOUT_CYCLES idle cycles in a turn state.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      synchronous active-low reset
//   start        begin a new game (honoured in IDLE or DONE only)
//   move_valid   a move is presented on move_cell
//   move_cell    target cell, row*3+col, legal 0..8
//   game_done    win logic: game finished on the current board
//   winner       win logic: 11 player1, 10 player2, 01 tie, 00 none
//   board        cell i at [2i+1:2i]; 00 empty, 11 player1, 10 player2
//   turn         11 player1 to move, 10 player2 to move, 00 otherwise
//   move_ready   high while a player may move
//   move_reject  one-cycle pulse after an illegal move
//   game_over    high while the game is finished
//   result       latched winner code, valid while game_over
//   p1_wins, p2_wins, ties   game tallies, saturating at 15
// -----------------------------------------------------------------------------
module ttt_game_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  input  logic        game_done,
  input  logic [1:0]  winner,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic        move_ready,
  output logic        move_reject,
  output logic        game_over,
  output logic [1:0]  result,
  output logic [3:0]  p1_wins,
  output logic [3:0]  p2_wins,
  output logic [3:0]  ties
);

  localparam logic [1:0] CODE_P1  = 2'b11;
  localparam logic [1:0] CODE_P2  = 2'b10;
  localparam logic [1:0] CODE_TIE = 2'b01;

  // A one-cycle timer window cannot express "count to TIMEOUT_CYCLES-1".
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("ttt_game_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    P1_TURN,
    P2_TURN,
    CHECK,
    DONE
  } state_t;

  state_t      state, state_next;
  logic        first_player, first_player_next;  // 1: player1 opened the current game
  logic        mover_p1, mover_p1_next;          // who made the move under CHECK
  logic [17:0] board_next;
  logic [1:0]  result_next;
  logic [3:0]  p1_wins_next, p2_wins_next, ties_next;
  logic        reject_next;

  logic        in_turn;
  logic [1:0]  player_code;
  logic [1:0]  cell_code;
  logic        cell_legal;
  logic        opener_p1;

`ifdef MOVE_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer;
`endif

  // Moore-style outputs decoded from the state.
  always_comb begin
    in_turn    = (state == P1_TURN) || (state == P2_TURN);
    move_ready = in_turn;
    game_over  = (state == DONE);
    unique case (state)
      P1_TURN: turn = CODE_P1;
      P2_TURN: turn = CODE_P2;
      default: turn = 2'b00;
    endcase
  end

  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next        = state;
    first_player_next = first_player;
    mover_p1_next     = mover_p1;
    board_next        = board;
    result_next       = result;
    p1_wins_next      = p1_wins;
    p2_wins_next      = p2_wins;
    ties_next         = ties;
    reject_next       = 1'b0;
    opener_p1         = first_player;

    player_code = (state == P1_TURN) ? CODE_P1 : CODE_P2;

    // Occupancy of the addressed cell; out-of-range indices match no cell.
    cell_code = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (move_cell == 4'(i)) cell_code = board[2*i +: 2];
    end
    cell_legal = (move_cell <= 4'd8) && (cell_code == 2'b00);

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          // A restart from DONE hands the opening move to the other player;
          // the first game after reset keeps the reset opener.
          if (state == DONE) begin
            opener_p1         = ~first_player;
            first_player_next = ~first_player;
          end
          board_next = '0;
          state_next = opener_p1 ? P1_TURN : P2_TURN;
        end
      end

      P1_TURN, P2_TURN: begin
        if (move_valid && cell_legal) begin
          for (int i = 0; i < 9; i++) begin
            if (move_cell == 4'(i)) board_next[2*i +: 2] = player_code;
          end
          mover_p1_next = (state == P1_TURN);
          state_next    = CHECK;
        end else begin
          reject_next = move_valid;
`ifdef MOVE_TIMEOUT_EN
          // Forfeit only when no legal move arrived on the final cycle.
          if (timer == TIMER_LAST) begin
            state_next = (state == P1_TURN) ? P2_TURN : P1_TURN;
          end
`endif
        end
      end

      CHECK: begin
        if (game_done) begin
          result_next = winner;
          if (winner == CODE_P1 && p1_wins != 4'hF) p1_wins_next = p1_wins + 4'd1;
          if (winner == CODE_P2 && p2_wins != 4'hF) p2_wins_next = p2_wins + 4'd1;
          if (winner == CODE_TIE && ties != 4'hF)   ties_next    = ties + 4'd1;
          state_next = DONE;
        end else begin
          state_next = mover_p1 ? P2_TURN : P1_TURN;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      first_player <= 1'b1;
      mover_p1     <= 1'b0;
      board        <= '0;
      result       <= 2'b00;
      p1_wins      <= '0;
      p2_wins      <= '0;
      ties         <= '0;
      move_reject  <= 1'b0;
    end else begin
      state        <= state_next;
      first_player <= first_player_next;
      mover_p1     <= mover_p1_next;
      board        <= board_next;
      result       <= result_next;
      p1_wins      <= p1_wins_next;
      p2_wins      <= p2_wins_next;
      ties         <= ties_next;
      move_reject  <= reject_next;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  // Restarts on every state change so each turn gets a full window,
  // including a turn entered through a forfeit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!in_turn || (state_next != state)) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ttt_game_ctrl
//   Bench for ttt_game_ctrl. It plays scripted games against the DUT,
//   supplying game_done/winner from a small win-logic function on the DUT
//   board. A game-level model (board array, phase, whose move, game counts)
//   predicts every output. This model is compared on each falling edge, and
//   literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_ttt_game_ctrl;

`ifdef MOVE_TIMEOUT_EN
  localparam int TIMEOUT = 4;
`else
  localparam int TIMEOUT = 1023;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start, move_valid, game_done;
  logic [3:0]  move_cell;
  logic [1:0]  winner;
  logic [17:0] board;
  logic [1:0]  turn, result;
  logic        move_ready, move_reject, game_over;
  logic [3:0]  p1_wins, p2_wins, ties;

  int n_checks = 0;
  int n_errors = 0;

  ttt_game_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .move_valid(move_valid),
    .move_cell(move_cell), .game_done(game_done), .winner(winner),
    .board(board), .turn(turn), .move_ready(move_ready),
    .move_reject(move_reject), .game_over(game_over), .result(result),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .ties(ties)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Win logic: {done, winner} for a packed board.
  function automatic logic [2:0] judge(input logic [17:0] b);
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [1:0] c [9];
    int filled = 0;
    for (int i = 0; i < 9; i++) begin
      c[i] = b[2*i +: 2];
      if (c[i] != 2'b00) filled++;
    end
    for (int l = 0; l < 8; l++) begin
      if (c[lines[l][0]] != 2'b00 && c[lines[l][0]] == c[lines[l][1]] &&
          c[lines[l][1]] == c[lines[l][2]])
        return {1'b1, c[lines[l][0]]};
    end
    if (filled == 9) return 3'b101;
    return 3'b000;
  endfunction

  always_comb {game_done, winner} = judge(board);

  // ---------------- game-level model ----------------
  int m_board [9];
  int m_phase;          // 0 idle, 1 someone to move, 2 judging, 3 finished
  bit m_p1_move;        // player to move (phase 1) / player who just moved (phase 2)
  int m_games;          // games started since reset; even index -> player1 opens
  int m_result;
  int m_p1_total, m_p2_total, m_tie_total;
  bit m_reject;
  int m_idle;
  bit m_valid = 1'b0;

  function automatic logic [17:0] model_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  always @(posedge clk) begin
    logic [2:0] j;
    if (!reset_n) begin
      foreach (m_board[i]) m_board[i] = 0;
      m_phase = 0; m_p1_move = 1'b1; m_games = 0; m_result = 0;
      m_p1_total = 0; m_p2_total = 0; m_tie_total = 0;
      m_reject = 1'b0; m_idle = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_reject = 1'b0;
      case (m_phase)
        0, 3: if (start) begin
          if (m_phase == 3) m_games++;
          foreach (m_board[i]) m_board[i] = 0;
          m_p1_move = (m_games % 2 == 0);
          m_phase = 1;
          m_idle = 0;
        end
        1: begin
          if (move_valid && move_cell <= 8 && m_board[move_cell] == 0) begin
            m_board[move_cell] = m_p1_move ? 3 : 2;
            m_phase = 2;
          end else begin
            if (move_valid) m_reject = 1'b1;
            if (m_idle == TIMEOUT - 1 && TIMEOUT != 1023) begin
              m_p1_move = !m_p1_move;
              m_idle = 0;
            end else begin
              m_idle++;
            end
          end
        end
        default: begin
          j = judge(model_board());
          if (j[2]) begin
            m_result = int'(j[1:0]);
            if (j[1:0] == 2'b11) m_p1_total++;
            if (j[1:0] == 2'b10) m_p2_total++;
            if (j[1:0] == 2'b01) m_tie_total++;
            m_phase = 3;
          end else begin
            m_p1_move = !m_p1_move;
            m_phase = 1;
            m_idle = 0;
          end
        end
      endcase
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("board",       board,       model_board());
      check("turn",        turn,        (m_phase == 1) ? (m_p1_move ? 2'b11 : 2'b10) : 2'b00);
      check("move_ready",  move_ready,  m_phase == 1);
      check("move_reject", move_reject, m_reject);
      check("game_over",   game_over,   m_phase == 3);
      if (m_phase == 3) check("result", result, m_result);
      check("p1_wins",     p1_wins,     sat15(m_p1_total));
      check("p2_wins",     p2_wins,     sat15(m_p2_total));
      check("ties",        ties,        sat15(m_tie_total));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (move_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (move_ready !== 1'b1) check("ready_wait", move_ready, 1);
  endtask

  task automatic move(input int c);
    wait_ready();
    move_valid = 1'b1;
    move_cell  = 4'(c);
    tick();
    move_valid = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic try_illegal(input int c, input logic [17:0] exp_board);
    move_valid = 1'b1;
    move_cell  = 4'(c);
    tick();
    move_valid = 1'b0;
    check("reject_pulse", move_reject, 1);
    check("reject_board", board, exp_board);
    check("reject_turn",  turn, 2'b10);
    tick();
    check("reject_clear", move_reject, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
    repeat (2) tick();
    check("rst_board", board, 18'h0);
    check("rst_turn", turn, 2'b00);
    check("rst_over", game_over, 0);
    reset_n = 1'b1;
    tick();

    // Game A: player1 opens, illegal moves, tie on the ninth move.
    start_game();
    check("open_p1", turn, 2'b11);
    move(0);
    wait_ready();
    try_illegal(0, 18'h00003);
    try_illegal(9, 18'h00003);
    move(4); move(2); move(1); move(7); move(6); move(3); move(5); move(8);
    tick();
    check("tie_result", result, 2'b01);
    check("tie_count", ties, 4'd1);
    check("tie_over", game_over, 1);

    // Game B: player2 opens and wins; stray start and held move_valid ignored.
    start_game();
    check("open_p2", turn, 2'b10);
    check("open_clear", board, 18'h0);
    move(0);
    wait_ready();
    start = 1'b1; tick(); start = 1'b0;
    check("start_ignored", turn, 2'b11);
    move_valid = 1'b1; move_cell = 4'd3;
    tick(); tick();
    move_valid = 1'b0;
    check("check_no_reject", move_reject, 0);
    move(1); move(4); move(2);
    tick();
    check("p2_result", result, 2'b10);
    check("p2_count", p2_wins, 4'd1);
    move_valid = 1'b1; move_cell = 4'd5; tick(); move_valid = 1'b0;
    check("done_no_reject", move_reject, 0);

    // Game C: the reference win for player1.
    start_game();
    check("open_p1_again", turn, 2'b11);
    move(0); move(3); move(1); move(4); move(2);
    check("win_board", board, 18'h002BF);
    check("over_latency1", game_over, 0);
    tick();
    check("over_latency2", game_over, 1);
    check("win_result", result, 2'b11);
    check("win_count", p1_wins, 4'd1);

    // Fifteen more player1 wins: tally saturates at 15.
    for (int g = 0; g < 15; g++) begin
      start_game();
      if (m_p1_move) begin
        move(0); move(3); move(1); move(4); move(2);
      end else begin
        move(3); move(0); move(4); move(1); move(6); move(2);
      end
      tick();
    end
    check("sat_p1", p1_wins, 4'd15);
    check("keep_p2", p2_wins, 4'd1);
    check("keep_ties", ties, 4'd1);

    // Reset during player2's turn with move_valid and start asserted.
    start_game();
    if (m_p1_move) move(0);
    wait_ready();
    check("pre_reset_turn", turn, 2'b10);
    reset_n = 1'b0; move_valid = 1'b1; move_cell = 4'd5; start = 1'b1;
    tick();
    reset_n = 1'b1; move_valid = 1'b0; start = 1'b0;
    check("midrst_board", board, 18'h0);
    check("midrst_turn", turn, 2'b00);
    check("midrst_ready", move_ready, 0);
    check("midrst_reject", move_reject, 0);
    check("midrst_over", game_over, 0);
    check("midrst_result", result, 2'b00);
    check("midrst_p1", p1_wins, 4'd0);
    check("midrst_ties", ties, 4'd0);
    start_game();
    check("rst_opener", turn, 2'b11);

`ifdef MOVE_TIMEOUT_EN
    // Idle player1 forfeits after four cycles; player2 moves on its fourth.
    repeat (3) tick();
    check("to_not_yet", turn, 2'b11);
    tick();
    check("to_switch", turn, 2'b10);
    check("to_board", board, 18'h0);
    repeat (3) tick();
    move_valid = 1'b1; move_cell = 4'd4;
    tick();
    move_valid = 1'b0;
    check("to_move_board", board, 18'h00200);
    check("to_check_ready", move_ready, 0);
    tick();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, cycles a player may idle before forfeiting the turn (used only when MOVE_TIMEOUT_EN is defined).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  begin new game; honoured only in IDLE or DONE.
REQ-005 move_valid  input  1  requester presents a move.
REQ-006 move_cell  input  4  target cell, index = row*3+col, legal 0..8.
REQ-007 game_done  input  1  from win logic, combinational on board.
REQ-008 winner  input  2  from win logic: 11 player1, 10 player2, 01 tie, 00 none.
REQ-009 board  output  18  cell i at bits [2i+1:2i]; 00 empty, 11 player1, 10 player2.
REQ-010 turn  output  2  11 player1 to move, 10 player2 to move, 00 otherwise.
REQ-011 move_ready  output  1  high only in P1_TURN/P2_TURN.
REQ-012 move_reject  output  1  one-cycle pulse for an illegal move.
REQ-013 game_over  output  1  high in DONE.
REQ-014 result  output  2  latched winner code, valid while game_over.
REQ-015 p1_wins, p2_wins, ties  output  4 each  saturating game tallies.

Function
REQ-016 States: IDLE, P1_TURN, P2_TURN, CHECK, DONE.
REQ-017 IDLE/DONE + start: board cleared to 0, next state P1_TURN if first_player=1 else P2_TURN; first_player toggles on every start accepted in DONE (player1 opens the first game after reset).
REQ-018 Move accepted when move_valid & move_ready & move_cell<=8 & cell empty; cell written with current player code at that edge; next state CHECK.
REQ-019 Illegal move (move_cell>8 or cell occupied): board unchanged, move_reject pulses next cycle, state unchanged.
REQ-020 CHECK lasts exactly one cycle, samples game_done/winner on the updated board; move_ready low.
REQ-021 CHECK & game_done: result<=winner, increment p1_wins (11), p2_wins (10) or ties (01), go DONE.
REQ-022 CHECK & !game_done: go to the other player's turn state.
REQ-023 Accepted move to visible board update: 1 cycle; move to game_over: 2 cycles.
REQ-024 Tallies saturate at 15; no wrap.
REQ-025 start outside IDLE/DONE ignored; move_valid outside turn states ignored, no reject.
REQ-026 board, result and tallies hold in DONE until next start (tallies persist across games).

Reset
REQ-027 reset_n low at a clock edge: state IDLE, board 0, turn 00, move_ready 0, move_reject 0, game_over 0, result 00, tallies 0, first_player=player1, timer 0; applies mid-game and overrides start/move_valid.

Configuration
REQ-028 Macro MOVE_TIMEOUT_EN defined: turn timer clears on entering a turn state and counts each turn cycle; at count TIMEOUT_CYCLES-1 without an accepted move, board unchanged, state goes directly to the other player's turn; a legal move on that same cycle takes priority.
REQ-029 MOVE_TIMEOUT_EN undefined: no timer logic; a turn state waits indefinitely.

Verification
REQ-030 Reset, start, moves P1:0, P2:3, P1:1, P2:4, P1:2 -> board=18'h0003F (cells 0-2=11) plus cells 3,4=10, game_over 2 cycles after last move, result=11, p1_wins=1.
REQ-031 P2_TURN, move_cell=0 already held by player1 -> move_reject one cycle, board unchanged, turn stays 10; move_cell=9 -> same.
REQ-032 Full board with no line (winner=01 on ninth move) -> result=01, ties=1; next start -> board 0, player2 opens (turn=10).
REQ-033 16 player1 wins -> p1_wins stays 15.
REQ-034 reset_n low during P2_TURN with move_valid high -> next cycle IDLE, board 0, all outputs at reset values.
REQ-035 MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=4: P1_TURN idle 4 cycles -> turn=10, board unchanged; legal move on 4th cycle -> accepted, CHECK entered.
